// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkg
// Brief    : Shared types and constants for the USB full-speed transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_DATA0 = 3'd1,
        CMD_DATA1 = 3'd2,
        CMD_ACK   = 3'd3,
        CMD_NAK   = 3'd4,
        CMD_STALL = 3'd5,
        CMD_RSVD6 = 3'd6,
        CMD_RSVD7 = 3'd7
    } tx_cmd_e;

    localparam logic [7:0] c_SYNC_BYTE = 8'h80;
    localparam logic [7:0] c_PID_DATA0 = 8'hC3;
    localparam logic [7:0] c_PID_DATA1 = 8'h4B;
    localparam logic [7:0] c_PID_ACK   = 8'hD2;
    localparam logic [7:0] c_PID_NAK   = 8'h5A;
    localparam logic [7:0] c_PID_STALL = 8'h1E;

    localparam logic [6:0] c_MAX_PAYLOAD = 7'd64;

    localparam logic [15:0] c_CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] c_CRC16_POLY = 16'hA001;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t ST_IDLE    = 3'd0;
    localparam tx_state_t ST_SYNC    = 3'd1;
    localparam tx_state_t ST_PID     = 3'd2;
    localparam tx_state_t ST_DATA    = 3'd3;
    localparam tx_state_t ST_CRC_LO  = 3'd4;
    localparam tx_state_t ST_CRC_HI  = 3'd5;
    localparam tx_state_t ST_EOP_SE0 = 3'd6;
    localparam tx_state_t ST_EOP_J   = 3'd7;

    function automatic logic [7:0] pid_byte(input tx_cmd_e cmd);
        case (cmd)
            CMD_DATA0: pid_byte = c_PID_DATA0;
            CMD_DATA1: pid_byte = c_PID_DATA1;
            CMD_ACK:   pid_byte = c_PID_ACK;
            CMD_NAK:   pid_byte = c_PID_NAK;
            CMD_STALL: pid_byte = c_PID_STALL;
            default:   pid_byte = 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_crc16.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_crc16
// Brief    : Bit-serial reflected CRC16 (USB data CRC), raw register output.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        shift,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;
    logic        w_fb;
    logic [15:0] w_crc_next;

    assign w_fb       = r_crc[0] ^ bit_in;
    assign w_crc_next = (r_crc >> 1) ^ (w_fb ? c_CRC16_POLY : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            r_crc <= c_CRC16_INIT;
        end else if (shift) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_out = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder
// Brief    : USB packet serializer with NRZI, bit stuffing, CRC16 and EOP.
//            Define USB_TX_ERR_CHECK_EN to reject illegal commands via tx_error.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] tx_packet_data_size,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CLK = c_CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t          r_state;
    tx_state_t          w_next_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_ones;
    logic               r_stuff;
    logic               r_level;
    logic [6:0]         r_byte_cnt;
    logic [6:0]         r_size;
    tx_cmd_e            r_cmd;
    logic               r_get_d;
    logic [7:0]         r_data_buf;
    logic [15:0]        w_crc;

    tx_cmd_e w_cmd_in;
    logic    w_cmd_ok;
    logic    w_start;
    logic    w_serial;
    logic    w_bit_end;
    logic    w_data_bit;
    logic    w_cur_bit;
    logic    w_cur_level;
    logic    w_need_stuff;
    logic    w_advance;
    logic    w_byte_done;
    logic    w_is_data;
    logic    w_last_payload;
    logic    w_more_data;
    logic    w_get;
    logic    w_crc_shift;

    assign w_cmd_in = tx_cmd_e'(tx_packet);

    always_comb begin
        w_cmd_ok = 1'b0;
        case (w_cmd_in)
            CMD_DATA0, CMD_DATA1:         w_cmd_ok = 1'b1;
            CMD_ACK, CMD_NAK, CMD_STALL:  w_cmd_ok = 1'b1;
            default:                      w_cmd_ok = 1'b0;
        endcase
`ifdef USB_TX_ERR_CHECK_EN
        if ((w_cmd_in == CMD_DATA0 || w_cmd_in == CMD_DATA1) &&
            (tx_packet_data_size > c_MAX_PAYLOAD)) begin
            w_cmd_ok = 1'b0;
        end
`endif
    end

    assign w_start   = (r_state == ST_IDLE) && w_cmd_ok;
    assign w_serial  = (r_state == ST_SYNC) || (r_state == ST_PID) || (r_state == ST_DATA) ||
                       (r_state == ST_CRC_LO) || (r_state == ST_CRC_HI);
    assign w_bit_end = (r_clk_cnt == c_LAST_CLK);
    assign w_is_data = (r_cmd == CMD_DATA0) || (r_cmd == CMD_DATA1);

    // CRC bytes are read straight from the (inverted) CRC register, LSB first
    always_comb begin
        case (r_state)
            ST_CRC_LO: w_data_bit = ~w_crc[{1'b0, r_bit_cnt}];
            ST_CRC_HI: w_data_bit = ~w_crc[{1'b1, r_bit_cnt}];
            default:   w_data_bit = r_shift[0];
        endcase
    end

    assign w_cur_bit    = r_stuff ? 1'b0 : w_data_bit;
    assign w_cur_level  = w_cur_bit ? r_level : ~r_level;
    assign w_need_stuff = ~r_stuff & w_data_bit & (r_ones == 3'd5);
    // The data bit preceding a stuffed 0 is only retired at the end of the stuff bit
    assign w_advance    = w_serial & w_bit_end & ~w_need_stuff;
    assign w_byte_done  = w_advance & (r_bit_cnt == 3'd7);

    assign w_last_payload = ((r_byte_cnt + 7'd1) == r_size);
    assign w_more_data    = (r_state == ST_PID) ? (w_is_data && (r_size != 7'd0))
                                                : ((r_byte_cnt + 7'd1) < r_size);
    assign w_get          = ((r_state == ST_PID) || (r_state == ST_DATA)) &&
                            (r_bit_cnt == 3'd7) && (r_clk_cnt == '0) && !r_stuff && w_more_data;
    assign w_crc_shift    = (r_state == ST_DATA) && w_advance;

    usb_tx_crc16 u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (w_start),
        .shift   (w_crc_shift),
        .bit_in  (r_shift[0]),
        .crc_out (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_next_state = ST_SYNC;
            ST_SYNC:    if (w_byte_done) w_next_state = ST_PID;
            ST_PID: begin
                if (w_byte_done) begin
                    if (!w_is_data)            w_next_state = ST_EOP_SE0;
                    else if (r_size == 7'd0)   w_next_state = ST_CRC_LO;
                    else                       w_next_state = ST_DATA;
                end
            end
            ST_DATA:    if (w_byte_done && w_last_payload) w_next_state = ST_CRC_LO;
            ST_CRC_LO:  if (w_byte_done) w_next_state = ST_CRC_HI;
            ST_CRC_HI:  if (w_byte_done) w_next_state = ST_EOP_SE0;
            ST_EOP_SE0: if (w_bit_end && (r_bit_cnt == 3'd1)) w_next_state = ST_EOP_J;
            ST_EOP_J:   if (w_bit_end) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_transfer_active = (r_state != ST_IDLE);
        get_tx_packet_data = w_get;
        dplus_out          = 1'b1;
        dminus_out         = 1'b0;
        case (r_state)
            ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
                dplus_out  = w_cur_level;
                dminus_out = ~w_cur_level;
            end
            ST_EOP_SE0: begin
                dplus_out  = 1'b0;
                dminus_out = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_ones     <= 3'd0;
            r_stuff    <= 1'b0;
            r_level    <= 1'b1;
            r_byte_cnt <= 7'd0;
            r_size     <= 7'd0;
            r_cmd      <= CMD_NONE;
            r_get_d    <= 1'b0;
            r_data_buf <= 8'h00;
        end else begin
            r_get_d <= w_get;
            if (r_get_d) begin
                r_data_buf <= tx_packet_data;
            end

            if (r_state == ST_IDLE) begin
                r_clk_cnt  <= '0;
                r_bit_cnt  <= 3'd0;
                r_ones     <= 3'd0;
                r_stuff    <= 1'b0;
                r_level    <= 1'b1;
                r_byte_cnt <= 7'd0;
                if (w_start) begin
                    r_cmd   <= w_cmd_in;
                    r_size  <= tx_packet_data_size;
                    r_shift <= c_SYNC_BYTE;
                end
            end else begin
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;

                if (w_serial && w_bit_end) begin
                    r_level <= w_cur_level;
                    if (r_stuff) begin
                        r_stuff <= 1'b0;
                        r_ones  <= 3'd0;
                    end else if (w_need_stuff) begin
                        r_stuff <= 1'b1;
                        r_ones  <= 3'd0;
                    end else begin
                        r_ones <= w_data_bit ? r_ones + 3'd1 : 3'd0;
                    end
                end

                if (w_advance) begin
                    if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= 3'd0;
                        case (r_state)
                            ST_SYNC:         r_shift <= pid_byte(r_cmd);
                            ST_PID, ST_DATA: r_shift <= r_data_buf;
                            default:         r_shift <= r_shift;
                        endcase
                        if (r_state == ST_DATA) begin
                            r_byte_cnt <= r_byte_cnt + 7'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_shift   <= r_shift >> 1;
                    end
                end

                if (r_state == ST_EOP_SE0) begin
                    r_level <= 1'b1;
                    if (w_bit_end) begin
                        r_bit_cnt <= (r_bit_cnt == 3'd1) ? 3'd0 : r_bit_cnt + 3'd1;
                    end
                end
            end
        end
    end

`ifdef USB_TX_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == ST_IDLE) && (tx_packet != 3'd0) && !w_cmd_ok;
        end
    end

    assign tx_error = r_err;
`else
    assign tx_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 8, clk cycles per USB bit time (legal range >=4).
REQ-002 SHALL use one clock and a synchronous, active-high reset. Port order: clk, then rst.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 tx_packet  in  3  command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 illegal.
REQ-006 tx_packet_data_size  in  7  payload byte count for DATA0/DATA1 (0-64).
REQ-007 tx_packet_data  in  8  payload byte from the data buffer, valid one clk after a get pulse.
REQ-008 get_tx_packet_data  out  1  one-clk request for the next buffer byte.
REQ-009 tx_transfer_active  out  1  high while a packet is on the line.
REQ-010 tx_error  out  1  one-clk pulse on a rejected command.
REQ-011 dplus_out  out  1  D+ drive.
REQ-012 dminus_out  out  1  D- drive.

Function
REQ-013 Idle line SHALL be J (dplus_out=1, dminus_out=0). SE0 SHALL be 0/0.
REQ-014 FSM states SHALL be IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
REQ-015 In IDLE, a legal nonzero tx_packet SHALL be latched, and SYNC SHALL start on the next clk. tx_transfer_active SHALL rise on that same clk.
REQ-016 tx_packet SHALL be ignored outside IDLE.
REQ-017 Transmit order SHALL be: SYNC 0x80, then PID byte (DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E), then payload (DATA only), then CRC16 low byte, CRC16 high byte (DATA only), then 2 bit times SE0, then 1 bit time J. Every byte SHALL be sent LSB first.
REQ-018 Handshake packets (ACK/NAK/STALL) SHALL go PID -> EOP_SE0.
REQ-019 For a DATA packet with size 0, the FSM SHALL go PID -> CRC_LO.
REQ-020 NRZI: a 0 bit SHALL toggle the line state; a 1 bit SHALL hold it.
REQ-021 Bit stuffing: after six consecutive 1s (counted from the first SYNC bit through the last CRC bit), a 0 SHALL be inserted. The stuffed bit SHALL occupy a full bit time and reset the run count.
REQ-022 CRC16 SHALL cover payload bits only, before stuffing.
  - Init 0xFFFF.
  - Per bit: fb=crc[0]^bit; crc=crc>>1; if fb, crc^=0xA001.
  - Transmitted value SHALL be ~crc.
REQ-023 get_tx_packet_data SHALL pulse exactly once per payload byte, in the first clk of bit 7 of the preceding byte (PID or payload). The byte SHALL be latched CLKS_PER_BIT-1 clks later, with no idle gap on the line.
REQ-024 Exactly tx_packet_data_size get pulses SHALL occur per DATA packet.
REQ-025 A byte counter (7 bits) SHALL compare against the latched size and SHALL not wrap.
REQ-026 tx_transfer_active SHALL fall on the clk after the last EOP_J clk; the FSM SHALL return to IDLE on that clk.

Reset
REQ-027 rst SHALL force, on the next clk edge:
  - IDLE, J line, tx_transfer_active=0, get_tx_packet_data=0, tx_error=0.
  - CRC=0xFFFF, all counters 0.
  This SHALL hold even mid-packet; no EOP SHALL be sent.

Configuration
REQ-028 With USB_TX_ERR_CHECK_EN defined:
  - tx_packet 6/7, or DATA with size>64, SHALL pulse tx_error for one clk in IDLE.
  - No transmission SHALL start; tx_transfer_active SHALL stay 0.
REQ-029 Without USB_TX_ERR_CHECK_EN: tx_error SHALL be tied 0, illegal codes SHALL be ignored (stay IDLE), and any size SHALL be sent as given.

Structure
REQ-030 Package usb_pkg SHALL hold the tx_packet code enum, PID constants, the FSM state typedef, and CRC16 init/poly constants.
REQ-031 Bit-serial CRC SHALL be a sub-module usb_tx_crc16 with ports clk, rst, init, shift, bit_in, crc_out.

Verification
REQ-032 tx_packet=3 -> line J, then SYNC, PID 0xD2, SE0 x2, J; tx_transfer_active high for exactly 19*CLKS_PER_BIT clks; zero get pulses.
REQ-033 tx_packet=1, size 0 -> PID 0xC3, then CRC bytes 0x00 0x00 (16 NRZI toggles); zero get pulses; active 35 bit times.
REQ-034 tx_packet=2, size 2, data 0xFF 0x3F -> exactly 2 get pulses; a stuffed 0 after the 6th consecutive 1; line bit count = unstuffed + stuffed bits; CRC matches the REQ-022 model.
REQ-035 With USB_TX_ERR_CHECK_EN: tx_packet=6 -> tx_error high one clk, line stays J, active stays 0; without the macro, tx_error stays 0.
REQ-036 rst asserted during DATA byte 3 of 10 -> next clk J, active 0, no further get pulses; a following ACK command transmits correctly.
REQ-037 tx_packet changed from 1 to 4 mid-packet -> change ignored; DATA0 completes unchanged.
